// File: rtl/decode_stage_pkg.sv
// Shared types for the RV32I decode stage: decoded op enum, major opcodes
// and the entry record carried through the output FIFO.
package decode_stage_pkg;

  localparam int XLEN     = 32;
  localparam int REG_W    = 5;
  localparam int OP_WIDTH = 6;

  typedef enum logic [OP_WIDTH-1:0] {
    NOP,
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
  } op_e;

  localparam logic [6:0] OPC_OP     = 7'd51;
  localparam logic [6:0] OPC_OP_IMM = 7'd19;
  localparam logic [6:0] OPC_LOAD   = 7'd3;
  localparam logic [6:0] OPC_JALR   = 7'd103;
  localparam logic [6:0] OPC_STORE  = 7'd35;
  localparam logic [6:0] OPC_BRANCH = 7'd99;
  localparam logic [6:0] OPC_JAL    = 7'd111;
  localparam logic [6:0] OPC_AUIPC  = 7'd23;
  localparam logic [6:0] OPC_LUI    = 7'd55;

  typedef struct packed {
    op_e              op;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic             illegal;
  } entry_t;

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of the instruction-queue, fetch, predictor and dispatcher signals
// around the decode stage; slave is the stage side, master the environment.
interface decode_stage_if
  import decode_stage_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int INST_WIDTH    = 32,
  parameter int REG_IDX_WIDTH = 5
);
  logic                     rdy_in;
  logic                     flush_in;
  logic                     iq_valid_in;
  logic [INST_WIDTH-1:0]    iq_inst_in;
  logic [ADDR_WIDTH-1:0]    iq_pc_in;
  logic                     iq_ready_out;
  logic                     iq_flush_out;
  logic                     if_redirect_en_out;
  logic [ADDR_WIDTH-1:0]    if_redirect_addr_out;
  logic                     bp_query_en_out;
  logic [ADDR_WIDTH-1:0]    bp_pc_out;
  logic [ADDR_WIDTH-1:0]    bp_target_out;
  logic                     dp_valid_out;
  logic                     dp_ready_in;
  op_e                      dp_op_out;
  logic [REG_IDX_WIDTH-1:0] dp_rs_out;
  logic [REG_IDX_WIDTH-1:0] dp_rt_out;
  logic [REG_IDX_WIDTH-1:0] dp_rd_out;
  logic [INST_WIDTH-1:0]    dp_imm_out;
  logic [ADDR_WIDTH-1:0]    dp_pc_out;
  logic                     dp_illegal_out;

  modport master (
    output rdy_in, flush_in, iq_valid_in, iq_inst_in, iq_pc_in, dp_ready_in,
    input  iq_ready_out, iq_flush_out, if_redirect_en_out, if_redirect_addr_out,
           bp_query_en_out, bp_pc_out, bp_target_out, dp_valid_out, dp_op_out,
           dp_rs_out, dp_rt_out, dp_rd_out, dp_imm_out, dp_pc_out, dp_illegal_out
  );

  modport slave (
    input  rdy_in, flush_in, iq_valid_in, iq_inst_in, iq_pc_in, dp_ready_in,
    output iq_ready_out, iq_flush_out, if_redirect_en_out, if_redirect_addr_out,
           bp_query_en_out, bp_pc_out, bp_target_out, dp_valid_out, dp_op_out,
           dp_rs_out, dp_rt_out, dp_rd_out, dp_imm_out, dp_pc_out, dp_illegal_out
  );

endinterface

// File: rtl/decode_stage_comb.sv
// Purely combinational RV32I instruction -> decoded entry translation.
// Illegal encodings collapse to a NOP entry that keeps only pc and the flag.
module decode_comb
  import decode_stage_pkg::*;
(
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] pc,
  output entry_t          entry
);

  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [REG_W-1:0] rd, rs1, rs2;
  logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  logic             f7_ok;
  logic             bad;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign f7_ok  = (f7 == 7'h00) || (f7 == 7'h20);

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign shamt = {27'b0, inst[24:20]};

  always_comb begin
    bad      = 1'b0;
    entry    = '0;
    entry.pc = pc;
    case (opcode)
      OPC_LUI:   begin entry.op = LUI;   entry.rd = rd; entry.imm = imm_u; end
      OPC_AUIPC: begin entry.op = AUIPC; entry.rd = rd; entry.imm = imm_u; end
      OPC_JAL:   begin entry.op = JAL;   entry.rd = rd; entry.imm = imm_j; end
      OPC_JALR: begin
        entry.op = JALR; entry.rs = rs1; entry.rd = rd; entry.imm = imm_i;
      end
      OPC_BRANCH: begin
        entry.rs = rs1; entry.rt = rs2; entry.imm = imm_b;
        case (f3)
          3'd0:    entry.op = BEQ;
          3'd1:    entry.op = BNE;
          3'd4:    entry.op = BLT;
          3'd5:    entry.op = BGE;
          3'd6:    entry.op = BLTU;
          3'd7:    entry.op = BGEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        entry.rs = rs1; entry.rd = rd; entry.imm = imm_i;
        case (f3)
          3'd0:    entry.op = LB;
          3'd1:    entry.op = LH;
          3'd2:    entry.op = LW;
          3'd4:    entry.op = LBU;
          3'd5:    entry.op = LHU;
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        entry.rs = rs1; entry.rt = rs2; entry.imm = imm_s;
        case (f3)
          3'd0:    entry.op = SB;
          3'd1:    entry.op = SH;
          3'd2:    entry.op = SW;
          default: bad = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        entry.rs = rs1; entry.rd = rd; entry.imm = imm_i;
        case (f3)
          3'd0: entry.op = ADDI;
          3'd2: entry.op = SLTI;
          3'd3: entry.op = SLTIU;
          3'd4: entry.op = XORI;
          3'd6: entry.op = ORI;
          3'd7: entry.op = ANDI;
          // shifts carry funct7 in the immediate field, so the imm is just shamt
          3'd1: begin entry.op = SLLI; entry.imm = shamt; bad = !f7_ok; end
          3'd5: begin
            entry.op  = (f7 == 7'h20) ? SRAI : SRLI;
            entry.imm = shamt;
            bad       = !f7_ok;
          end
        endcase
      end
      OPC_OP: begin
        entry.rs = rs1; entry.rt = rs2; entry.rd = rd;
        bad = !f7_ok;
        case (f3)
          3'd0: entry.op = (f7 == 7'h20) ? SUB : ADD;
          3'd1: entry.op = SLL;
          3'd2: entry.op = SLT;
          3'd3: entry.op = SLTU;
          3'd4: entry.op = XOR;
          3'd5: entry.op = (f7 == 7'h20) ? SRA : SRL;
          3'd6: entry.op = OR;
          3'd7: entry.op = AND;
        endcase
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      entry         = '0;
      entry.pc      = pc;
      entry.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decoder, output FIFO, JAL redirect / branch query pulses.
// FSM: RUN = normal decode | DROP = swallow the wrong-path slot after a JAL.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int INST_WIDTH    = 32,
  parameter int REG_IDX_WIDTH = 5,
  parameter int BUF_DEPTH     = 2
)
(
  input logic           clk_in,
  input logic           rst_in,
  decode_stage_if.slave bus
);

  localparam int              PTR_W   = $clog2(BUF_DEPTH);
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(BUF_DEPTH);
  localparam logic [0:0]      ST_RUN  = 1'b0;
  localparam logic [0:0]      ST_DROP = 1'b1;

  logic [0:0]            state;
  entry_t                mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count;
  entry_t                dec, head;
  logic [XLEN-1:0]       target;
  logic                  enq, deq, is_jal, is_branch, pulse_ok;
  logic                  redirect_q, query_q;
  logic [ADDR_WIDTH-1:0] redirect_addr_q, bp_pc_q, bp_target_q;

  decode_comb u_decode_comb (
    .inst  (XLEN'(bus.iq_inst_in)),
    .pc    (XLEN'(bus.iq_pc_in)),
    .entry (dec)
  );

  assign target    = dec.pc + dec.imm;
  assign is_jal    = (dec.op == JAL);
  assign is_branch = dec.op inside {BEQ, BNE, BLT, BGE, BLTU, BGEU};
  assign head      = mem[rd_ptr];

  // ready ignores dp_ready_in: a full FIFO refuses even when draining this cycle
  assign bus.iq_ready_out = bus.rdy_in && !bus.flush_in &&
                            ((state == ST_RUN && count < DEPTH_C) || state == ST_DROP);
  assign enq              = bus.iq_valid_in && bus.iq_ready_out && (state == ST_RUN);
  assign bus.dp_valid_out = bus.rdy_in && (count != '0);
  assign deq              = bus.dp_valid_out && bus.dp_ready_in;

  assign pulse_ok                 = bus.rdy_in && !bus.flush_in;
  assign bus.if_redirect_en_out   = redirect_q && pulse_ok;
  assign bus.iq_flush_out         = redirect_q && pulse_ok;
  assign bus.if_redirect_addr_out = redirect_addr_q;
  assign bus.bp_query_en_out      = query_q && pulse_ok;
  assign bus.bp_pc_out            = bp_pc_q;
  assign bus.bp_target_out        = bp_target_q;

  assign bus.dp_op_out      = head.op;
  assign bus.dp_rs_out      = REG_IDX_WIDTH'(head.rs);
  assign bus.dp_rt_out      = REG_IDX_WIDTH'(head.rt);
  assign bus.dp_rd_out      = REG_IDX_WIDTH'(head.rd);
  assign bus.dp_imm_out     = INST_WIDTH'(head.imm);
  assign bus.dp_pc_out      = ADDR_WIDTH'(head.pc);
  assign bus.dp_illegal_out = head.illegal;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= ST_RUN;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      redirect_q      <= 1'b0;
      query_q         <= 1'b0;
      redirect_addr_q <= '0;
      bp_pc_q         <= '0;
      bp_target_q     <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (bus.rdy_in) begin
      if (bus.flush_in) begin
        state      <= ST_RUN;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        redirect_q <= 1'b0;
        query_q    <= 1'b0;
      end else begin
        if (enq) begin
          mem[wr_ptr] <= dec;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (deq) rd_ptr <= rd_ptr + 1'b1;
        case ({enq, deq})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase

        redirect_q <= enq && is_jal;
        query_q    <= enq && is_branch;
        if (enq && is_jal) redirect_addr_q <= ADDR_WIDTH'(target);
        if (enq && is_branch) begin
          bp_pc_q     <= ADDR_WIDTH'(dec.pc);
          bp_target_q <= ADDR_WIDTH'(target);
        end

        if (state == ST_DROP)      state <= ST_RUN;
        else if (enq && is_jal)    state <= ST_DROP;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a vector table for single-instruction decode
// plus hand-written sequences for JAL drop, branch query, backpressure, flush, rdy.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  decode_stage_if #(.ADDR_WIDTH(32), .INST_WIDTH(32), .REG_IDX_WIDTH(5)) bus ();

  decode_stage #(
    .ADDR_WIDTH(32), .INST_WIDTH(32), .REG_IDX_WIDTH(5), .BUF_DEPTH(2)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    op_e         op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [127:0] fields(input op_e op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [31:0] imm, input logic [31:0] pc,
                                          input logic ill);
    return 128'({op, rs, rt, rd, imm, pc, ill});
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 128'(act), 128'(exp));
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, 128'(act), 128'(exp));
  endtask

  task automatic chk_head(input string name, input op_e op, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] imm, input logic [31:0] pc, input logic ill);
    chk(name, fields(bus.dp_op_out, bus.dp_rs_out, bus.dp_rt_out, bus.dp_rd_out,
                     bus.dp_imm_out, bus.dp_pc_out, bus.dp_illegal_out),
        fields(op, rs, rt, rd, imm, pc, ill));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
    bus.iq_valid_in = 1'b1;
    bus.iq_inst_in  = inst;
    bus.iq_pc_in    = pc;
  endtask

  initial begin
    //          inst          pc          op     rs     rt     rd     imm            ill
    vecs[0]  = '{32'hFFB00093, 32'h100, ADDI,  5'd0,  5'd0,  5'd1,  32'hFFFFFFFB, 1'b0};
    vecs[1]  = '{32'h123452B7, 32'h104, LUI,   5'd0,  5'd0,  5'd5,  32'h12345000, 1'b0};
    vecs[2]  = '{32'hFFFFF117, 32'h108, AUIPC, 5'd0,  5'd0,  5'd2,  32'hFFFFF000, 1'b0};
    vecs[3]  = '{32'h00822183, 32'h10C, LW,    5'd4,  5'd0,  5'd3,  32'h00000008, 1'b0};
    vecs[4]  = '{32'hFE532E23, 32'h110, SW,    5'd6,  5'd5,  5'd0,  32'hFFFFFFFC, 1'b0};
    vecs[5]  = '{32'h40345393, 32'h114, SRAI,  5'd8,  5'd0,  5'd7,  32'h00000003, 1'b0};
    vecs[6]  = '{32'h40B504B3, 32'h118, SUB,   5'd10, 5'd11, 5'd9,  32'h00000000, 1'b0};
    vecs[7]  = '{32'h00C100E7, 32'h11C, JALR,  5'd2,  5'd0,  5'd1,  32'h0000000C, 1'b0};
    vecs[8]  = '{32'h0000007F, 32'h120, NOP,   5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1};
    vecs[9]  = '{32'h023100B3, 32'h124, NOP,   5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1};
    vecs[10] = '{32'h00003003, 32'h128, NOP,   5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1};
    vecs[11] = '{32'h00209463, 32'h12C, BNE,   5'd1,  5'd2,  5'd0,  32'h00000008, 1'b0};
    vecs[12] = '{32'h7FF27213, 32'h130, ANDI,  5'd4,  5'd0,  5'd4,  32'h000007FF, 1'b0};
    vecs[13] = '{32'h003110B3, 32'h134, SLL,   5'd2,  5'd3,  5'd1,  32'h00000000, 1'b0};

    bus.rdy_in      = 1'b0;
    bus.flush_in    = 1'b0;
    bus.iq_valid_in = 1'b0;
    bus.iq_inst_in  = '0;
    bus.iq_pc_in    = '0;
    bus.dp_ready_in = 1'b0;

    #1 rst = 1'b1;
    #2;
    chk1("rst_dp_valid", bus.dp_valid_out, 1'b0);
    chk1("rst_iq_ready", bus.iq_ready_out, 1'b0);
    chk_head("rst_dp_fields", NOP, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    chk("rst_pulses", 128'({bus.if_redirect_en_out, bus.iq_flush_out, bus.bp_query_en_out,
                            bus.if_redirect_addr_out, bus.bp_pc_out, bus.bp_target_out}), 128'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.rdy_in      = 1'b1;
    bus.dp_ready_in = 1'b1;
    #1;
    chk1("ready_after_rst", bus.iq_ready_out, 1'b1);

    for (int i = 0; i < 14; i++) begin
      step();
      offer(vecs[i].inst, vecs[i].pc);
      step();
      bus.iq_valid_in = 1'b0;
      chk1($sformatf("vec%0d_valid", i), bus.dp_valid_out, 1'b1);
      chk_head($sformatf("vec%0d_fields", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
               vecs[i].rd, vecs[i].imm, vecs[i].pc, vecs[i].ill);
      step();
    end

    // JAL: redirect pulse next cycle, wrong-path slot swallowed
    step();
    offer(32'h008000EF, 32'h200);
    step();
    chk1("jal_redirect_en", bus.if_redirect_en_out, 1'b1);
    chk1("jal_iq_flush", bus.iq_flush_out, 1'b1);
    chk32("jal_redirect_addr", bus.if_redirect_addr_out, 32'h208);
    chk_head("jal_head", JAL, 5'd0, 5'd0, 5'd1, 32'h8, 32'h200, 1'b0);
    offer(32'h00100113, 32'h204);
    #1;
    chk1("drop_iq_ready", bus.iq_ready_out, 1'b1);
    step();
    bus.iq_valid_in = 1'b0;
    chk1("jal_pulse_one_cycle", bus.if_redirect_en_out, 1'b0);
    chk1("drop_not_enqueued", bus.dp_valid_out, 1'b0);
    step();
    chk1("drop_still_empty", bus.dp_valid_out, 1'b0);

    // BEQ backward: predictor query with wrapped target
    offer(32'hFE208EE3, 32'h300);
    step();
    bus.iq_valid_in = 1'b0;
    chk1("beq_query_en", bus.bp_query_en_out, 1'b1);
    chk32("beq_bp_target", bus.bp_target_out, 32'h2FC);
    chk32("beq_bp_pc", bus.bp_pc_out, 32'h300);
    chk_head("beq_head", BEQ, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 32'h300, 1'b0);
    step();
    chk1("beq_query_one_cycle", bus.bp_query_en_out, 1'b0);

    // backpressure: FIFO of 2 fills, third waits, drains in order
    bus.dp_ready_in = 1'b0;
    offer(32'h00100093, 32'h500);
    step();
    chk1("bp_ready_count1", bus.iq_ready_out, 1'b1);
    offer(32'h00200113, 32'h504);
    step();
    offer(32'h00300193, 32'h508);
    chk1("full_refuses", bus.iq_ready_out, 1'b0);
    chk_head("full_head_i1", ADDI, 5'd0, 5'd0, 5'd1, 32'h1, 32'h500, 1'b0);
    step();
    chk1("full_still_refuses", bus.iq_ready_out, 1'b0);
    bus.dp_ready_in = 1'b1;
    #1;
    chk1("full_refuses_with_deq", bus.iq_ready_out, 1'b0);
    step();
    chk_head("drain_head_i2", ADDI, 5'd0, 5'd0, 5'd2, 32'h2, 32'h504, 1'b0);
    chk1("drain_ready_again", bus.iq_ready_out, 1'b1);
    step();
    bus.iq_valid_in = 1'b0;
    chk1("enq_deq_valid", bus.dp_valid_out, 1'b1);
    chk_head("drain_head_i3", ADDI, 5'd0, 5'd0, 5'd3, 32'h3, 32'h508, 1'b0);
    step();
    chk1("drained_empty", bus.dp_valid_out, 1'b0);

    // flush with two entries and a pending JAL redirect
    bus.dp_ready_in = 1'b0;
    offer(32'h00100093, 32'h600);
    step();
    offer(32'h008000EF, 32'h604);
    step();
    bus.iq_valid_in = 1'b0;
    chk_head("pre_flush_head", ADDI, 5'd0, 5'd0, 5'd1, 32'h1, 32'h600, 1'b0);
    bus.flush_in = 1'b1;
    #1;
    chk1("flush_cancels_redirect", bus.if_redirect_en_out, 1'b0);
    chk1("flush_cancels_iq_flush", bus.iq_flush_out, 1'b0);
    chk1("flush_iq_ready", bus.iq_ready_out, 1'b0);
    step();
    bus.flush_in = 1'b0;
    #1;
    chk1("flush_empties", bus.dp_valid_out, 1'b0);
    chk1("flush_ready_run", bus.iq_ready_out, 1'b1);
    chk1("no_redirect_after_flush", bus.if_redirect_en_out, 1'b0);
    offer(32'h00200113, 32'h700);
    step();
    bus.iq_valid_in = 1'b0;
    chk1("post_flush_valid", bus.dp_valid_out, 1'b1);
    chk_head("post_flush_head", ADDI, 5'd0, 5'd0, 5'd2, 32'h2, 32'h700, 1'b0);

    // rdy_in low freezes everything and masks the handshakes
    bus.rdy_in = 1'b0;
    #1;
    chk1("frozen_dp_valid", bus.dp_valid_out, 1'b0);
    chk1("frozen_iq_ready", bus.iq_ready_out, 1'b0);
    bus.dp_ready_in = 1'b1;
    step();
    step();
    bus.rdy_in = 1'b1;
    #1;
    chk1("thaw_dp_valid", bus.dp_valid_out, 1'b1);
    chk_head("thaw_head", ADDI, 5'd0, 5'd0, 5'd2, 32'h2, 32'h700, 1'b0);
    step();
    chk1("thaw_drained", bus.dp_valid_out, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
